// File: rtl/cpu_dbus_bridge.sv
// cpu_dbus_bridge: data-memory port to valid/ready bus bridge with a posted write slot and timeout abort
//
// Ports:
//   clock, reset            system clock; asynchronous active-low reset
//   cpu_addr/ren/wen        CPU request (byte address, load, store)
//   cpu_wdata/cpu_be        lane-aligned store data and byte enables
//   cpu_rdata               load data, valid when cpu_ready=1 after a load completes
//   cpu_ready               registered; 1 = request may be accepted / pipeline may advance
//   bus_valid/we/addr       bus request, direction, word-aligned address
//   bus_wdata/bus_be        write data and byte enables (4'hF on reads)
//   bus_ready/bus_rdata     target handshake and read data
//   err_count               saturating count of timeouts
//   proto_err               sticky flag: load and store requested together
module cpu_dbus_bridge #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic [7:0]  err_count,
    output logic        proto_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] AMASK = 32'hFFFF_FFFC;

    // RESP is the extra cycle between the read handshake and cpu_ready rising
    typedef enum logic [2:0] {IDLE, WR, WR_WR, WR_RD, RD, RESP} state_t;
    state_t state;

    logic [TW-1:0] tcnt;
    logic [31:0]   pend_addr;
    logic [31:0]   pend_wdata;
    logic [3:0]    pend_be;
    logic          tmo;
    logic          done;
    logic          take_r;
    logic          take_w;

    // A timeout ends the transaction exactly like a handshake would
    assign tmo    = bus_valid & ~bus_ready & (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign done   = bus_valid & (bus_ready | tmo);
    // A simultaneous load and store services the load and drops the store
    assign take_r = cpu_ready & cpu_ren;
    assign take_w = cpu_ready & cpu_wen & ~cpu_ren;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cpu_ready  <= 1'b1;
            cpu_rdata  <= '0;
            bus_valid  <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            bus_be     <= '0;
            err_count  <= '0;
            proto_err  <= 1'b0;
            tcnt       <= '0;
            pend_addr  <= '0;
            pend_wdata <= '0;
            pend_be    <= '0;
        end else begin
            tcnt <= done ? '0 : bus_valid ? tcnt + TW'(1) : tcnt;
            if (tmo && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            if (cpu_ready && cpu_ren && cpu_wen)
                proto_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (take_r) begin
                        bus_valid <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= cpu_addr & AMASK;
                        bus_be    <= 4'hF;
                        cpu_ready <= 1'b0;
                        state     <= RD;
                    end else if (take_w) begin
                        bus_valid <= 1'b1;
                        bus_we    <= 1'b1;
                        bus_addr  <= cpu_addr & AMASK;
                        bus_wdata <= cpu_wdata;
                        bus_be    <= cpu_be;
                        state     <= WR;
                    end
                end
                WR: begin
                    if (take_r) begin
                        cpu_ready <= 1'b0;
                        if (done) begin
                            bus_we   <= 1'b0;
                            bus_addr <= cpu_addr & AMASK;
                            bus_be   <= 4'hF;
                            state    <= RD;
                        end else begin
                            pend_addr <= cpu_addr & AMASK;
                            state     <= WR_RD;
                        end
                    end else if (take_w) begin
                        if (done) begin
                            bus_addr  <= cpu_addr & AMASK;
                            bus_wdata <= cpu_wdata;
                            bus_be    <= cpu_be;
                        end else begin
                            pend_addr  <= cpu_addr & AMASK;
                            pend_wdata <= cpu_wdata;
                            pend_be    <= cpu_be;
                            cpu_ready  <= 1'b0;
                            state      <= WR_WR;
                        end
                    end else if (done) begin
                        bus_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WR_WR: begin
                    if (done) begin
                        bus_addr  <= pend_addr;
                        bus_wdata <= pend_wdata;
                        bus_be    <= pend_be;
                        cpu_ready <= 1'b1;
                        state     <= WR;
                    end
                end
                WR_RD: begin
                    if (done) begin
                        bus_we   <= 1'b0;
                        bus_addr <= pend_addr;
                        bus_be   <= 4'hF;
                        state    <= RD;
                    end
                end
                RD: begin
                    if (done) begin
                        cpu_rdata <= tmo ? ERR_RDATA : bus_rdata;
                        bus_valid <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_dbus_bridge.sv
// tb_cpu_dbus_bridge: directed self-checking bench for cpu_dbus_bridge
module tb_cpu_dbus_bridge;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic        cpu_ren = 1'b0;
    logic        cpu_wen = 1'b0;
    logic [31:0] cpu_wdata = '0;
    logic [3:0]  cpu_be = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata = '0;
    logic [7:0]  err_count;
    logic        proto_err;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } xfer_t;

    xfer_t log_q[$];
    int    delay = 0;
    bit    stuck = 1'b0;
    int    wcnt = 0;
    int    checks = 0;
    int    errors = 0;

    cpu_dbus_bridge #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEADBEEF)) dut (
        .clock(clock), .reset(reset),
        .cpu_addr(cpu_addr), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .err_count(err_count), .proto_err(proto_err)
    );

    always #5 clock = ~clock;

    // Bus target: accepts after 'delay' waiting cycles, never while stuck; logs every handshake
    assign bus_ready = bus_valid && !stuck && (wcnt >= delay);

    always @(posedge clock) begin
        if (bus_valid && bus_ready)
            log_q.push_back(xfer_t'({bus_we, bus_addr, bus_wdata, bus_be}));
        wcnt <= (!bus_valid || bus_ready) ? 0 : wcnt + 1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
        int i;
        cpu_ren = r;
        cpu_wen = w;
        cpu_addr = a;
        cpu_wdata = d;
        cpu_be = b;
        i = 0;
        while (cpu_ready !== 1'b1 && i < 100) begin
            i++;
            tick;
        end
        checks++;
        if (cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: cpu_ready=%b, required 1", cpu_ready);
        end
        tick;
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (cpu_ready !== 1'b1 && n < 100) begin
            n++;
            tick;
        end
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 100 && bus_valid; i++) tick;
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        tick;
        tick;
        checks++;
        if (cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_cpu_ready: got %b, expected 1", cpu_ready); end
        checks++;
        if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h, expected 0", cpu_rdata); end
        checks++;
        if ({bus_valid, bus_we} !== 2'b00) begin errors++; $display("FAIL reset_bus_ctl: got %b, expected 00", {bus_valid, bus_we}); end
        checks++;
        if ({bus_addr, bus_wdata, bus_be} !== 68'h0) begin errors++; $display("FAIL reset_bus_fields: got %h, expected 0", {bus_addr, bus_wdata, bus_be}); end
        checks++;
        if ({err_count, proto_err} !== 9'h0) begin errors++; $display("FAIL reset_err: got %h, expected 0", {err_count, proto_err}); end
        reset = 1'b1;
        tick;
    endtask

    task automatic test_lone_sw;
        int  vcnt;
        bit  low;
        bit  unst;
        delay = 3;
        log_q.delete();
        send(1'b0, 1'b1, 32'h100, 32'h11223344, 4'hF);
        vcnt = 0;
        low = 1'b0;
        unst = 1'b0;
        while (bus_valid && vcnt < 50) begin
            vcnt++;
            if (cpu_ready !== 1'b1) low = 1'b1;
            if ({bus_we, bus_addr, bus_wdata, bus_be} !== {1'b1, 32'h100, 32'h11223344, 4'hF}) unst = 1'b1;
            tick;
        end
        checks++;
        if (vcnt !== 4) begin errors++; $display("FAIL lone_sw_valid_cycles: got %0d, expected 4", vcnt); end
        checks++;
        if (low !== 1'b0) begin errors++; $display("FAIL lone_sw_stall: cpu_ready dropped, expected never 0"); end
        checks++;
        if (unst !== 1'b0) begin errors++; $display("FAIL lone_sw_stable: bus fields changed, expected stable"); end
        checks++;
        if (log_q.size() !== 1) begin errors++; $display("FAIL lone_sw_count: got %0d transfers, expected 1", log_q.size()); end
        else begin
            checks++;
            if (log_q[0] !== xfer_t'({1'b1, 32'h100, 32'h11223344, 4'hF})) begin errors++; $display("FAIL lone_sw_xfer: got %h, expected %h", log_q[0], xfer_t'({1'b1, 32'h100, 32'h11223344, 4'hF})); end
        end
    endtask

    task automatic test_load;
        int n;
        delay = 0;
        bus_rdata = 32'hCAFEF00D;
        log_q.delete();
        send(1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
        wait_ready(n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL load_stall: got %0d cycles, expected 2", n); end
        checks++;
        if (cpu_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL load_rdata: got %h, expected cafef00d", cpu_rdata); end
        checks++;
        if (log_q.size() !== 1) begin errors++; $display("FAIL load_count: got %0d transfers, expected 1", log_q.size()); end
        else begin
            checks++;
            if ({log_q[0].we, log_q[0].addr, log_q[0].be} !== {1'b0, 32'h200, 4'hF}) begin errors++; $display("FAIL load_xfer: got %h, expected %h", {log_q[0].we, log_q[0].addr, log_q[0].be}, {1'b0, 32'h200, 4'hF}); end
        end
        bus_rdata = 32'h0;
        tick;
        tick;
        checks++;
        if (cpu_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL load_hold: got %h, expected cafef00d", cpu_rdata); end
    endtask

    task automatic test_sw_then_lw;
        int n;
        delay = 2;
        bus_rdata = 32'h13572468;
        log_q.delete();
        send(1'b0, 1'b1, 32'h300, 32'h55AA55AA, 4'hF);
        send(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        wait_ready(n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL sw_lw_stall: got %0d cycles, expected 6", n); end
        checks++;
        if (cpu_rdata !== 32'h13572468) begin errors++; $display("FAIL sw_lw_rdata: got %h, expected 13572468", cpu_rdata); end
        checks++;
        if (log_q.size() !== 2) begin errors++; $display("FAIL sw_lw_count: got %0d transfers, expected 2", log_q.size()); end
        else begin
            checks++;
            if (log_q[0] !== xfer_t'({1'b1, 32'h300, 32'h55AA55AA, 4'hF})) begin errors++; $display("FAIL sw_lw_first: got %h, expected write to 300", log_q[0]); end
            checks++;
            if ({log_q[1].we, log_q[1].addr, log_q[1].be} !== {1'b0, 32'h300, 4'hF}) begin errors++; $display("FAIL sw_lw_second: got %h, expected read of 300", log_q[1]); end
        end
    endtask

    task automatic test_back_to_back;
        int n;
        delay = 1;
        log_q.delete();
        send(1'b0, 1'b1, 32'h400, 32'hA0A0A0A0, 4'h3);
        send(1'b0, 1'b1, 32'h404, 32'hB0B0B0B0, 4'hC);
        wait_ready(n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL b2b_stall: got %0d cycles, expected 1", n); end
        wait_idle;
        checks++;
        if (log_q.size() !== 2) begin errors++; $display("FAIL b2b_count: got %0d transfers, expected 2", log_q.size()); end
        else begin
            checks++;
            if (log_q[0] !== xfer_t'({1'b1, 32'h400, 32'hA0A0A0A0, 4'h3})) begin errors++; $display("FAIL b2b_first: got %h, expected write A to 400", log_q[0]); end
            checks++;
            if (log_q[1] !== xfer_t'({1'b1, 32'h404, 32'hB0B0B0B0, 4'hC})) begin errors++; $display("FAIL b2b_second: got %h, expected write B to 404", log_q[1]); end
        end
    endtask

    task automatic test_back_to_back_zero_wait;
        delay = 0;
        log_q.delete();
        send(1'b0, 1'b1, 32'h500, 32'h01020304, 4'hF);
        send(1'b0, 1'b1, 32'h504, 32'h05060708, 4'h1);
        checks++;
        if ({cpu_ready, bus_valid, bus_addr} !== {1'b1, 1'b1, 32'h504}) begin errors++; $display("FAIL b2b0_overlap: got ready/valid/addr %h, expected 1/1/504", {cpu_ready, bus_valid, bus_addr}); end
        wait_idle;
        checks++;
        if (log_q.size() !== 2) begin errors++; $display("FAIL b2b0_count: got %0d transfers, expected 2", log_q.size()); end
        else begin
            checks++;
            if ({log_q[0].addr, log_q[1].addr, log_q[1].wdata} !== {32'h500, 32'h504, 32'h05060708}) begin errors++; $display("FAIL b2b0_order: got %h %h, expected 500 then 504", log_q[0].addr, log_q[1].addr); end
        end
    endtask

    task automatic test_timeout;
        int vcnt;
        int n;
        stuck = 1'b1;
        log_q.delete();
        send(1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
        vcnt = 0;
        while (bus_valid && vcnt < 50) begin
            vcnt++;
            tick;
        end
        wait_ready(n);
        checks++;
        if (vcnt !== 8) begin errors++; $display("FAIL timeout_valid_cycles: got %0d, expected 8", vcnt); end
        checks++;
        if (cpu_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b, expected 1", cpu_ready); end
        checks++;
        if (cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL timeout_rdata: got %h, expected deadbeef", cpu_rdata); end
        checks++;
        if (err_count !== 8'd1) begin errors++; $display("FAIL timeout_err_count: got %0d, expected 1", err_count); end
        checks++;
        if (log_q.size() !== 0) begin errors++; $display("FAIL timeout_no_xfer: got %0d transfers, expected 0", log_q.size()); end
        stuck = 1'b0;
    endtask

    task automatic test_proto_err;
        int n;
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_err_clear: got %b, expected 0", proto_err); end
        delay = 0;
        bus_rdata = 32'h600DCAFE;
        log_q.delete();
        send(1'b1, 1'b1, 32'h603, 32'hFFFFFFFF, 4'hF);
        wait_ready(n);
        tick;
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_err_set: got %b, expected 1", proto_err); end
        checks++;
        if (cpu_rdata !== 32'h600DCAFE) begin errors++; $display("FAIL proto_err_rdata: got %h, expected 600dcafe", cpu_rdata); end
        checks++;
        if (log_q.size() !== 1) begin errors++; $display("FAIL proto_err_count: got %0d transfers, expected 1", log_q.size()); end
        else begin
            checks++;
            if ({log_q[0].we, log_q[0].addr} !== {1'b0, 32'h600}) begin errors++; $display("FAIL proto_err_xfer: got %h, expected read of 600", log_q[0]); end
        end
    endtask

    task automatic test_err_saturate;
        int n;
        stuck = 1'b1;
        for (int i = 0; i < 260; i++) begin
            send(1'b1, 1'b0, 32'h900, 32'h0, 4'h0);
            wait_ready(n);
        end
        checks++;
        if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d, expected 255", err_count); end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_rd;
        int n;
        stuck = 1'b1;
        send(1'b1, 1'b0, 32'h800, 32'h0, 4'h0);
        tick;
        tick;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus_valid, bus_we, cpu_ready} !== 3'b001) begin errors++; $display("FAIL rst_mid_ctl: got valid/we/ready %b, expected 001", {bus_valid, bus_we, cpu_ready}); end
        checks++;
        if ({bus_addr, bus_wdata, bus_be, cpu_rdata} !== 100'h0) begin errors++; $display("FAIL rst_mid_data: got %h, expected 0", {bus_addr, bus_wdata, bus_be, cpu_rdata}); end
        checks++;
        if ({err_count, proto_err} !== 9'h0) begin errors++; $display("FAIL rst_mid_err: got %h, expected 0", {err_count, proto_err}); end
        @(posedge clock);
        #1 reset = 1'b1;
        stuck = 1'b0;
        tick;
        checks++;
        if (bus_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_discard: bus_valid %b, expected 0", bus_valid); end
        delay = 0;
        bus_rdata = 32'h0F0F0F0F;
        send(1'b1, 1'b0, 32'hA00, 32'h0, 4'h0);
        wait_ready(n);
        checks++;
        if ({n, cpu_rdata} !== {32'd2, 32'h0F0F0F0F}) begin errors++; $display("FAIL rst_mid_recover: got stall %0d rdata %h, expected 2 0f0f0f0f", n, cpu_rdata); end
    endtask

    initial begin
        test_reset;
        test_lone_sw;
        test_load;
        test_sw_then_lw;
        test_back_to_back;
        test_back_to_back_zero_wait;
        test_timeout;
        test_proto_err;
        test_err_saturate;
        test_reset_mid_rd;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
